ps2_led_host_ctrl: RTL and testbench

- Host-to-device PS/2 command sequencer that configures keyboard LEDs (Scroll/Num/Caps).
- Sends command 0xED, then the LED byte, each over the bidirectional PS/2 lines, and waits for a 0xFA acknowledge.
- Shares the PS/2 clock/data pair with the existing scan-code receive path. Exposes busy so downstream logic can ignore response bytes (0xFA/0xFE) during a transaction.

---
 rtl/ps2_led_host_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_led_host_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_led_host_ctrl.sv
// PS/2 host-to-device LED command sequencer: sends 0xED then the LED byte and waits for 0xFA.
// Optional `LOCK_KEY_TRACK_EN adds key_code input so lock-key make codes toggle the LEDs.
module ps2_led_host_ctrl #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int BIT_TIMEOUT    = 750000,
    parameter int ACK_TIMEOUT    = 1000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       led_req,
    input  logic [2:0] led_val,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    input  logic [7:0] rx_code,
    input  logic       rx_valid,
`ifdef LOCK_KEY_TRACK_EN
    input  logic [7:0] key_code,
`endif
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] led_state
);
    // state    | meaning
    // IDLE     | waiting for led_req / pending request
    // INHIBIT  | clock held low for INHIBIT_CYCLES
    // START    | data pulled low (start bit), clock still low
    // SEND     | shifting data/parity/stop on device falling edges
    // LINE_ACK | waiting for device to pull data low on the next edge
    // RESP     | waiting for 0xFA / 0xFE response byte
    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_SEND, S_LINE_ACK, S_RESP
    } state_t;

    localparam int T_A  = (INHIBIT_CYCLES > BIT_TIMEOUT) ? INHIBIT_CYCLES : BIT_TIMEOUT;
    localparam int T_M  = (T_A > ACK_TIMEOUT) ? T_A : ACK_TIMEOUT;
    localparam int TW   = $clog2(T_M + 1);
    localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t state, state_nxt;
    logic [TW-1:0] timer, load_val;
    logic          timer_load, timer_tc;
    logic [3:0]    bit_idx;
    logic          tx_oe, byte_sel, bit_val;
    logic [RW-1:0] retry;
    logic          retry_max;
    logic [2:0]    val_lat, pending_val, req_val, start_val;
    logic          pending, req_any;
    logic [7:0]    cur_byte;
    logic          ps2c_s1, ps2c_s2, ps2c_q, ps2d_s1, ps2d_s2, fall_c;
    logic          start_txn, ack_fa, ack_fe, timeout;

`ifdef LOCK_KEY_TRACK_EN
    logic [2:0] shadow, key_mask;

    always_comb begin
        case (key_code)
            8'h58:   key_mask = 3'b100;
            8'h77:   key_mask = 3'b010;
            8'h7E:   key_mask = 3'b001;
            default: key_mask = 3'b000;
        endcase
        req_any = led_req | (|key_mask);
        req_val = led_req ? led_val : (shadow ^ key_mask);
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset)            shadow <= 3'b000;
        else if (led_req)     shadow <= led_val;
        else if (|key_mask)   shadow <= shadow ^ key_mask;
    end
`else
    always_comb begin
        req_any = led_req;
        req_val = led_val;
    end
`endif

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            ps2c_s1 <= 1'b1; ps2c_s2 <= 1'b1; ps2c_q <= 1'b1;
            ps2d_s1 <= 1'b1; ps2d_s2 <= 1'b1;
        end else begin
            ps2c_s1 <= ps2c_in; ps2c_s2 <= ps2c_s1; ps2c_q <= ps2c_s2;
            ps2d_s1 <= ps2d_in; ps2d_s2 <= ps2d_s1;
        end
    end

    always_comb begin
        fall_c    = ps2c_q & ~ps2c_s2;
        timer_tc  = (timer == '0);
        retry_max = (retry == RW'(MAX_RETRY));
        cur_byte  = byte_sel ? {5'b00000, val_lat} : 8'hED;
        if (bit_idx < 4'd8)       bit_val = cur_byte[bit_idx[2:0]];
        else if (bit_idx == 4'd8) bit_val = ~^cur_byte;
        else                      bit_val = 1'b1;
        start_txn = (state == S_IDLE) && (req_any || pending);
        start_val = req_any ? req_val : pending_val;
        ack_fa    = rx_valid && (rx_code == 8'hFA);
        ack_fe    = rx_valid && (rx_code == 8'hFE);
        timeout   = 1'b0;
        case (state)
            S_SEND:     timeout = timer_tc && !fall_c;
            // a high data line on the ack edge is handled like a lost device
            S_LINE_ACK: timeout = fall_c ? ps2d_s2 : timer_tc;
            S_RESP:     timeout = timer_tc && !ack_fa && !ack_fe;
            default:    timeout = 1'b0;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = retry_max ? S_IDLE : S_INHIBIT;
        end else begin
            case (state)
                S_IDLE:     if (start_txn) state_nxt = S_INHIBIT;
                S_INHIBIT:  if (timer_tc) state_nxt = S_START;
                S_START:    state_nxt = S_SEND;
                S_SEND:     if (fall_c && bit_idx == 4'd9) state_nxt = S_LINE_ACK;
                S_LINE_ACK: if (fall_c) state_nxt = S_RESP;
                S_RESP: begin
                    if (ack_fa)      state_nxt = byte_sel ? S_IDLE : S_INHIBIT;
                    else if (ack_fe) state_nxt = S_INHIBIT;
                end
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state != S_IDLE);
        ps2c_oe = (state == S_INHIBIT) || (state == S_START);
        ps2d_oe = (state == S_START) || ((state == S_SEND) && tx_oe);
    end

    // timer reloads on every state entry and on each clock edge while sending
    always_comb begin
        timer_load = (state_nxt != state) || ((state == S_SEND) && fall_c);
        case (state_nxt)
            S_INHIBIT:          load_val = TW'(INHIBIT_CYCLES - 1);
            S_SEND, S_LINE_ACK: load_val = TW'(BIT_TIMEOUT - 1);
            S_RESP:             load_val = TW'(ACK_TIMEOUT - 1);
            default:            load_val = '0;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            timer       <= '0;
            bit_idx     <= 4'd0;
            tx_oe       <= 1'b0;
            byte_sel    <= 1'b0;
            retry       <= '0;
            val_lat     <= 3'b000;
            pending     <= 1'b0;
            pending_val <= 3'b000;
            led_state   <= 3'b000;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            if (timer_load)     timer <= load_val;
            else if (!timer_tc) timer <= timer - TW'(1);

            done  <= (state == S_RESP) && ack_fa && byte_sel;
            error <= timeout && retry_max;

            if (state == S_START) begin
                bit_idx <= 4'd0;
                tx_oe   <= 1'b1;
            end else if ((state == S_SEND) && fall_c) begin
                bit_idx <= bit_idx + 4'd1;
                tx_oe   <= ~bit_val;
            end

            if (start_txn) begin
                val_lat  <= start_val;
                byte_sel <= 1'b0;
                retry    <= '0;
            end else if (timeout && !retry_max) begin
                retry    <= retry + RW'(1);
                byte_sel <= 1'b0;
            end else if ((state == S_RESP) && ack_fa && !byte_sel) begin
                byte_sel <= 1'b1;
            end

            if ((state == S_RESP) && ack_fa && byte_sel) led_state <= val_lat;

            if (start_txn) begin
                pending <= 1'b0;
            end else if (req_any) begin
                pending     <= 1'b1;
                pending_val <= req_val;
            end
        end
    end
endmodule

// File: tb/tb_ps2_led_host_ctrl.sv
// Directed bench for ps2_led_host_ctrl with a simple wired-AND PS/2 keyboard model.
module tb_ps2_led_host_ctrl;
    localparam int INH = 20;
    localparam int BTO = 200;
    localparam int ATO = 300;
    localparam int MR  = 2;

    logic       clk_50mhz = 1'b0;
    logic       reset = 1'b1;
    logic       led_req = 1'b0;
    logic [2:0] led_val = 3'b000;
    logic [7:0] rx_code = 8'h00;
    logic       rx_valid = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2c_oe, ps2d_oe, busy, done, error;
    logic [2:0] led_state;
    logic       ps2c_line, ps2d_line;
`ifdef LOCK_KEY_TRACK_EN
    logic [7:0] key_code = 8'h00;
`endif
    int n_chk = 0;
    int n_bad = 0;
    int done_cnt = 0;

    assign ps2c_line = ~ps2c_oe & dev_clk;
    assign ps2d_line = ~ps2d_oe & dev_data;

    always #10 clk_50mhz = ~clk_50mhz;

    ps2_led_host_ctrl #(
        .INHIBIT_CYCLES(INH), .BIT_TIMEOUT(BTO), .ACK_TIMEOUT(ATO), .MAX_RETRY(MR)
    ) dut (
        .clk_50mhz(clk_50mhz), .reset(reset), .led_req(led_req), .led_val(led_val),
        .ps2c_in(ps2c_line), .ps2d_in(ps2d_line), .rx_code(rx_code), .rx_valid(rx_valid),
`ifdef LOCK_KEY_TRACK_EN
        .key_code(key_code),
`endif
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .busy(busy), .done(done), .error(error),
        .led_state(led_state)
    );

    always @(posedge clk_50mhz) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] c);
        rx_code  = c;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_code  = 8'h00;
    endtask

    task automatic pulse_req(input logic [2:0] v);
        led_val = v;
        led_req = 1'b1;
        tick();
        led_req = 1'b0;
    endtask

    // keyboard side of one host-to-device frame, including the line ack
    task automatic dev_frame(output logic [7:0] b, output logic par, output logic stop,
                             output int inh, output logic ok);
        logic [9:0] bits;
        int t;
        b = 8'h00; par = 1'b0; stop = 1'b0; inh = 0; ok = 1'b0; bits = '0; t = 0;
        while (!ps2c_oe && t < 2000) begin tick(); t++; end
        if (!ps2c_oe) return;
        while (ps2c_oe && inh < 2000) begin tick(); inh++; end
        if (ps2c_oe || !ps2d_oe) return;
        repeat (10) tick();
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (15) tick();
            bits[i] = ps2d_line;
            dev_clk = 1'b1;
            repeat (15) tick();
        end
        dev_data = 1'b0;
        repeat (3) tick();
        dev_clk = 1'b0;
        repeat (15) tick();
        dev_clk = 1'b1;
        repeat (3) tick();
        dev_data = 1'b1;
        repeat (5) tick();
        b = bits[7:0]; par = bits[8]; stop = bits[9]; ok = 1'b1;
    endtask

    task automatic do_byte(input string tag, input logic [7:0] eb, input logic ep);
        logic [7:0] b;
        logic par, stop, ok;
        int inh;
        dev_frame(b, par, stop, inh, ok);
        check_eq({tag, "_frame_ok"}, ok, 1);
        check_eq({tag, "_byte"}, b, eb);
        check_eq({tag, "_parity"}, par, ep);
        check_eq({tag, "_stop"}, stop, 1);
        check_eq({tag, "_inhibit_len"}, inh, INH + 1);
    endtask

    task automatic finish_txn(input string tag, input logic [2:0] v, input logic ep);
        do_byte({tag, "_cmd"}, 8'hED, 1'b1);
        send_rx(8'hFA);
        do_byte({tag, "_led"}, {5'b00000, v}, ep);
        send_rx(8'hFA);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_led_state"}, led_state, v);
        check_eq({tag, "_busy_at_done"}, busy, 0);
        tick();
        check_eq({tag, "_done_clear"}, done, 0);
        check_eq({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int attempts;
        logic prev_c, err_seen;

        repeat (3) tick();
        check_eq("rst_ps2c_oe", ps2c_oe, 0);
        check_eq("rst_ps2d_oe", ps2d_oe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_led_state", led_state, 0);
        reset = 1'b0;
        repeat (5) tick();

        // basic transaction 3'b101
        pulse_req(3'b101);
        check_eq("t1_busy", busy, 1);
        finish_txn("t1", 3'b101, 1'b1);

        // 0xFE resend of the command byte
        pulse_req(3'b011);
        do_byte("t2_cmd_a", 8'hED, 1'b1);
        send_rx(8'hFE);
        check_eq("t2_retry_after_fe", dut.retry, 0);
        finish_txn("t2", 3'b011, 1'b1);

        // silent device: initial attempt + MAX_RETRY, then error
        pulse_req(3'b110);
        attempts = 0; prev_c = 1'b0; err_seen = 1'b0;
        for (int i = 0; i < 5000 && !err_seen; i++) begin
            if (ps2c_oe && !prev_c) attempts++;
            prev_c = ps2c_oe;
            if (error) err_seen = 1'b1;
            else tick();
        end
        check_eq("t3_error_seen", err_seen, 1);
        check_eq("t3_attempts", attempts, MR + 1);
        check_eq("t3_led_state", led_state, 3'b011);
        check_eq("t3_ps2c_oe", ps2c_oe, 0);
        check_eq("t3_ps2d_oe", ps2d_oe, 0);
        check_eq("t3_busy", busy, 0);
        tick();
        check_eq("t3_error_clear", error, 0);

        // request arriving mid-transaction becomes pending
        pulse_req(3'b001);
        do_byte("t4a_cmd", 8'hED, 1'b1);
        pulse_req(3'b010);
        send_rx(8'hFA);
        do_byte("t4a_led", 8'h01, 1'b0);
        send_rx(8'hFA);
        check_eq("t4a_done", done, 1);
        check_eq("t4a_led_state", led_state, 3'b001);
        tick();
        check_eq("t4_pending_start", busy, 1);
        finish_txn("t4b", 3'b010, 1'b0);

        // reset in the middle of SEND
        pulse_req(3'b111);
        for (int i = 0; i < 2000 && ps2c_oe; i++) tick();
        repeat (10) tick();
        for (int i = 0; i < 4; i++) begin
            dev_clk = 1'b0; repeat (15) tick();
            dev_clk = 1'b1; repeat (15) tick();
        end
        dev_clk = 1'b0;
        repeat (8) tick();
        check_eq("t5_busy_before_rst", busy, 1);
        reset = 1'b1;
        tick();
        check_eq("t5_rst_ps2c_oe", ps2c_oe, 0);
        check_eq("t5_rst_ps2d_oe", ps2d_oe, 0);
        check_eq("t5_rst_busy", busy, 0);
        reset = 1'b0;
        dev_clk = 1'b1;
        repeat (10) tick();
        pulse_req(3'b100);
        finish_txn("t5", 3'b100, 1'b0);
        check_eq("done_count", done_cnt, 5);

`ifdef LOCK_KEY_TRACK_EN
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        key_code = 8'h58;
        tick();
        key_code = 8'h00;
        finish_txn("k1", 3'b100, 1'b0);
        key_code = 8'h58;
        tick();
        key_code = 8'h00;
        finish_txn("k2", 3'b000, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
